// File: rtl/div_share_sched.sv
// rtl/div_share_sched.sv - two-port round-robin scheduler for a shared slow divider (optional DIV_ZERO_BYPASS_EN)
module div_share_sched #(
    parameter int NW      = 5,
    parameter int DW      = 4,
    parameter int TIMEOUT = 31
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [NW-1:0] req_n0,
    input  logic [NW-1:0] req_n1,
    input  logic [DW-1:0] req_d0,
    input  logic [DW-1:0] req_d1,
    output logic [1:0]    resp_valid,
    input  logic [1:0]    resp_ready,
    output logic [NW-1:0] resp_q,
    output logic [DW-1:0] resp_r,
    output logic          resp_err,
    output logic          div_start,
    output logic [NW-1:0] div_n,
    output logic [DW-1:0] div_d,
    input  logic [NW-1:0] div_q,
    input  logic [DW-1:0] div_r,
    input  logic          div_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          owner_q, owner_d;
    logic [NW-1:0] div_n_q, div_n_d;
    logic [DW-1:0] div_d_q, div_d_d;
    logic [NW-1:0] resp_q_q, resp_q_d;
    logic [DW-1:0] resp_r_q, resp_r_d;
    logic          resp_err_q, resp_err_d;
    logic [7:0]    wd_cnt_q, wd_cnt_d;

    logic          any_valid;
    logic          grant_port;
    logic [NW-1:0] sel_n;
    logic [DW-1:0] sel_d;
    logic [8:0]    wd_next;
    logic [7:0]    wd_sat;
    logic          timeout_hit;

    // Round-robin pick: on a tie the port not served last wins; otherwise the lone valid port.
    always_comb begin
        any_valid  = |req_valid;
        if (req_valid == 2'b11) begin
            grant_port = ~last_grant_q;
        end else begin
            grant_port = req_valid[1];
        end
        sel_n = grant_port ? req_n1 : req_n0;
        sel_d = grant_port ? req_d1 : req_d0;
    end

    // Saturating watchdog increment and the "reaches TIMEOUT this cycle" test.
    always_comb begin
        wd_next     = {1'b0, wd_cnt_q} + 9'd1;
        wd_sat      = wd_next[8] ? 8'hFF : wd_next[7:0];
        timeout_hit = (wd_sat >= TIMEOUT_C);
    end

    // Next-state and handshake outputs for the IDLE/ISSUE/WAIT/RESP sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        div_n_d      = div_n_q;
        div_d_d      = div_d_q;
        resp_q_d     = resp_q_q;
        resp_r_d     = resp_r_q;
        resp_err_d   = resp_err_q;
        wd_cnt_d     = wd_cnt_q;
        req_ready    = 2'b00;
        resp_valid   = 2'b00;
        div_start    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Ready is withheld during reset so nothing is accepted then.
                if (any_valid && !reset) begin
                    req_ready[grant_port] = 1'b1;
                    owner_d      = grant_port;
                    last_grant_d = grant_port;
                    div_n_d      = sel_n;
                    div_d_d      = sel_d;
                    state_d      = S_ISSUE;
`ifdef DIV_ZERO_BYPASS_EN
                    // Divide-by-zero is answered locally without touching the divider.
                    if (sel_d == '0) begin
                        state_d    = S_RESP;
                        resp_q_d   = '1;
                        resp_r_d   = sel_n[DW-1:0];
                        resp_err_d = 1'b1;
                    end
`endif
                end
            end
            S_ISSUE: begin
                div_start = 1'b1;
                wd_cnt_d  = 8'd0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                wd_cnt_d = wd_sat;
                if (div_done) begin
                    resp_q_d   = div_q;
                    resp_r_d   = div_r;
                    resp_err_d = 1'b0;
                    state_d    = S_RESP;
                end else if (timeout_hit) begin
                    resp_q_d   = '1;
                    resp_r_d   = '0;
                    resp_err_d = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid[owner_q] = 1'b1;
                if (resp_ready[owner_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            div_n_q      <= '0;
            div_d_q      <= '0;
            resp_q_q     <= '0;
            resp_r_q     <= '0;
            resp_err_q   <= 1'b0;
            wd_cnt_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            div_n_q      <= div_n_d;
            div_d_q      <= div_d_d;
            resp_q_q     <= resp_q_d;
            resp_r_q     <= resp_r_d;
            resp_err_q   <= resp_err_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    assign div_n    = div_n_q;
    assign div_d    = div_d_q;
    assign resp_q   = resp_q_q;
    assign resp_r   = resp_r_q;
    assign resp_err = resp_err_q;

endmodule

// File: tb/tb_div_share_sched.sv
// tb/tb_div_share_sched.sv - directed self-checking bench for div_share_sched
module tb_div_share_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [4:0] req_n0 = 5'd0, req_n1 = 5'd0;
    logic [3:0] req_d0 = 4'd0, req_d1 = 4'd0;
    logic [1:0] resp_valid;
    logic [1:0] resp_ready = 2'b00;
    logic [4:0] resp_q;
    logic [3:0] resp_r;
    logic       resp_err;
    logic       div_start;
    logic [4:0] div_n;
    logic [3:0] div_d;
    logic [4:0] div_q = 5'd0;
    logic [3:0] div_r = 4'd0;
    logic       div_done = 1'b0;

    int vectors = 0;
    int errors  = 0;
    int cycle   = 0;
    bit div_hang = 1'b0;
    int div_cnt = -1;

    div_share_sched #(.NW(5), .DW(4), .TIMEOUT(31)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_n0(req_n0), .req_n1(req_n1), .req_d0(req_d0), .req_d1(req_d1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_q(resp_q), .resp_r(resp_r), .resp_err(resp_err),
        .div_start(div_start), .div_n(div_n), .div_d(div_d),
        .div_q(div_q), .div_r(div_r), .div_done(div_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Divider model: done three cycles after start unless hung.
    always @(negedge clk) begin
        int nn, dd;
        if (reset) begin
            div_cnt  = -1;
            div_done = 1'b0;
        end else begin
            div_done = 1'b0;
            if (div_cnt > 0) begin
                div_cnt--;
                if (div_cnt == 0) begin
                    if (!div_hang) begin
                        nn = int'(div_n);
                        dd = int'(div_d);
                        div_done = 1'b1;
                        if (dd == 0) begin
                            div_q = 5'h1f;
                            div_r = div_n[3:0];
                        end else begin
                            div_q = 5'(nn / dd);
                            div_r = 4'(nn % dd);
                        end
                    end
                    div_cnt = -1;
                end
            end
            if (div_start) div_cnt = 3;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_valid = 2'b00;
        resp_ready = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Waits for resp_valid[port]; reports starts, timing and any req_ready seen while busy.
    task automatic wait_resp(input int port, input int limit, output int starts,
                             output int waited, output bit seen, output int start_cyc,
                             output int resp_cyc, output logic [1:0] rr_seen);
        starts = 0; waited = 0; seen = 1'b0; start_cyc = -1; resp_cyc = -1; rr_seen = 2'b00;
        while (!seen && waited < limit) begin
            if (resp_valid[port]) begin
                seen = 1'b1;
                resp_cyc = cycle;
            end else begin
                if (div_start) begin
                    starts++;
                    start_cyc = cycle;
                end
                rr_seen = rr_seen | req_ready;
                tick();
                waited++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b exp 00", req_ready); end
        vectors++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid got %b exp 00", resp_valid); end
        vectors++; if (resp_q !== 5'd0 || resp_r !== 4'd0 || resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp got q=%0d r=%0d e=%b exp 0/0/0", resp_q, resp_r, resp_err); end
        vectors++; if (div_start !== 1'b0 || div_n !== 5'd0 || div_d !== 4'd0) begin errors++; $display("FAIL rst_div got s=%b n=%0d d=%0d exp 0/0/0", div_start, div_n, div_d); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int st, w, sc, rc; bit seen; logic [1:0] rr;
        req_n0 = 5'd5; req_d0 = 4'd2; req_valid = 2'b01;
        #1;
        vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready got %b exp 01", req_ready); end
        tick();
        req_valid = 2'b00;
        wait_resp(0, 20, st, w, seen, sc, rc, rr);
        vectors++; if (!seen) begin errors++; $display("FAIL single_resp_seen got 0 exp 1"); end
        vectors++; if (st !== 1) begin errors++; $display("FAIL single_starts got %0d exp 1", st); end
        vectors++; if (rr[1] !== 1'b0) begin errors++; $display("FAIL single_ready1 got %b exp 0", rr[1]); end
        vectors++; if (resp_valid !== 2'b01 || resp_q !== 5'd2 || resp_r !== 4'd1 || resp_err !== 1'b0) begin errors++; $display("FAIL single_resp got v=%b q=%0d r=%0d e=%b exp 01/2/1/0", resp_valid, resp_q, resp_r, resp_err); end
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
        vectors++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL single_resp_drop got %b exp 00", resp_valid); end
    endtask

    task automatic test_port1();
        int st, w, sc, rc; bit seen; logic [1:0] rr;
        req_n1 = 5'd10; req_d1 = 4'd6; req_valid = 2'b10;
        #1;
        vectors++; if (req_ready !== 2'b10) begin errors++; $display("FAIL p1_req_ready got %b exp 10", req_ready); end
        tick();
        req_valid = 2'b00;
        wait_resp(1, 20, st, w, seen, sc, rc, rr);
        vectors++; if (!seen || resp_valid !== 2'b10 || resp_q !== 5'd1 || resp_r !== 4'd4) begin errors++; $display("FAIL p1_resp got v=%b q=%0d r=%0d exp 10/1/4", resp_valid, resp_q, resp_r); end
        for (int k = 0; k < 2; k++) begin
            vectors++; if (div_n !== 5'd10 || div_d !== 4'd6) begin errors++; $display("FAIL p1_div_hold got n=%0d d=%0d exp 10/6", div_n, div_d); end
            tick();
        end
        resp_ready = 2'b10;
        tick();
        resp_ready = 2'b00;
        vectors++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL p1_resp_drop got %b exp 00", resp_valid); end
    endtask

    task automatic test_back_to_back();
        int st, w, sc, rc; bit seen; logic [1:0] rr;
        apply_reset();
        req_n0 = 5'd7; req_d0 = 4'd3; req_n1 = 5'd9; req_d1 = 4'd4;
        req_valid = 2'b11;
        #1;
        vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL tie1_grant got %b exp 01", req_ready); end
        tick();
        req_valid = 2'b10;
        wait_resp(0, 20, st, w, seen, sc, rc, rr);
        vectors++; if (!seen || resp_q !== 5'd2 || resp_r !== 4'd1) begin errors++; $display("FAIL tie1_resp0 got q=%0d r=%0d exp 2/1", resp_q, resp_r); end
        vectors++; if (rr !== 2'b00) begin errors++; $display("FAIL tie1_busy_ready got %b exp 00", rr); end
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
        req_valid = 2'b11;
        #1;
        vectors++; if (req_ready !== 2'b10) begin errors++; $display("FAIL tie2_grant got %b exp 10", req_ready); end
        tick();
        req_valid = 2'b01;
        wait_resp(1, 20, st, w, seen, sc, rc, rr);
        vectors++; if (!seen || resp_valid !== 2'b10 || resp_q !== 5'd2 || resp_r !== 4'd1) begin errors++; $display("FAIL tie2_resp1 got v=%b q=%0d r=%0d exp 10/2/1", resp_valid, resp_q, resp_r); end
        resp_ready = 2'b10;
        tick();
        resp_ready = 2'b00;
        vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_grant got %b exp 01", req_ready); end
        tick();
        req_valid = 2'b00;
        wait_resp(0, 20, st, w, seen, sc, rc, rr);
        vectors++; if (!seen || resp_q !== 5'd2 || resp_r !== 4'd1) begin errors++; $display("FAIL b2b_resp0 got q=%0d r=%0d exp 2/1", resp_q, resp_r); end
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
    endtask

    task automatic test_timeout();
        int st, w, sc, rc; bit seen; logic [1:0] rr;
        div_hang = 1'b1;
        req_n0 = 5'd20; req_d0 = 4'd3; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        wait_resp(0, 60, st, w, seen, sc, rc, rr);
        vectors++; if (!seen) begin errors++; $display("FAIL to_seen got 0 exp 1"); end
        vectors++; if (rc - sc !== 32) begin errors++; $display("FAIL to_latency got %0d exp 32", rc - sc); end
        vectors++; if (resp_q !== 5'd31 || resp_r !== 4'd0 || resp_err !== 1'b1) begin errors++; $display("FAIL to_resp got q=%0d r=%0d e=%b exp 31/0/1", resp_q, resp_r, resp_err); end
        div_hang = 1'b0;
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
    endtask

    task automatic test_div_zero();
        int st, w, sc, rc; bit seen; logic [1:0] rr;
        req_n0 = 5'd13; req_d0 = 4'd0; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        wait_resp(0, 20, st, w, seen, sc, rc, rr);
        vectors++; if (!seen) begin errors++; $display("FAIL dz_seen got 0 exp 1"); end
`ifdef DIV_ZERO_BYPASS_EN
        vectors++; if (w !== 0) begin errors++; $display("FAIL dz_latency got %0d exp 0", w); end
        vectors++; if (st !== 0) begin errors++; $display("FAIL dz_starts got %0d exp 0", st); end
        vectors++; if (resp_q !== 5'd31 || resp_r !== 4'd13 || resp_err !== 1'b1) begin errors++; $display("FAIL dz_resp got q=%0d r=%0d e=%b exp 31/13/1", resp_q, resp_r, resp_err); end
`else
        vectors++; if (st !== 1) begin errors++; $display("FAIL dz_starts got %0d exp 1", st); end
        vectors++; if (resp_err !== 1'b0) begin errors++; $display("FAIL dz_err got %b exp 0", resp_err); end
`endif
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
    endtask

    task automatic test_reset_hold();
        int st, w, sc, rc; bit seen; logic [1:0] rr;
        div_hang = 1'b1;
        req_n1 = 5'd6; req_d1 = 4'd1; req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        vectors++; if (resp_valid !== 2'b00 || div_start !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL mid_rst_ctrl got v=%b s=%b rr=%b exp 00/0/00", resp_valid, div_start, req_ready); end
        vectors++; if (div_n !== 5'd0 || div_d !== 4'd0 || resp_q !== 5'd0 || resp_r !== 4'd0 || resp_err !== 1'b0) begin errors++; $display("FAIL mid_rst_data got n=%0d d=%0d q=%0d r=%0d e=%b exp zeros", div_n, div_d, resp_q, resp_r, resp_err); end
        reset = 1'b0;
        div_hang = 1'b0;
        tick();
        wait_resp(1, 10, st, w, seen, sc, rc, rr);
        vectors++; if (seen) begin errors++; $display("FAIL mid_rst_dropped got resp exp none"); end
        req_n0 = 5'd29; req_d0 = 4'd5; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        wait_resp(0, 20, st, w, seen, sc, rc, rr);
        vectors++; if (!seen) begin errors++; $display("FAIL hold_seen got 0 exp 1"); end
        for (int k = 0; k < 3; k++) begin
            resp_ready = (k == 1) ? 2'b10 : 2'b00;
            vectors++; if (resp_valid !== 2'b01 || resp_q !== 5'd5 || resp_r !== 4'd4 || resp_err !== 1'b0) begin errors++; $display("FAIL hold_stable%0d got v=%b q=%0d r=%0d e=%b exp 01/5/4/0", k, resp_valid, resp_q, resp_r, resp_err); end
            tick();
        end
        resp_ready = 2'b01;
        #1;
        vectors++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL hold_still got %b exp 01", resp_valid); end
        tick();
        resp_ready = 2'b00;
        vectors++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL hold_release got %b exp 00", resp_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_port1();
        test_back_to_back();
        test_timeout();
        test_div_zero();
        test_reset_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
